mem_interconnect: RTL and testbench

MEM_INTERCONNECT -- requirements
Module: mem_interconnect

---
 rtl/mem_bus_pkg.sv | 14 +
 rtl/mem_decoder.sv | 28 ++
 rtl/mem_interconnect.sv | 162 ++++++++++++++++
 tb/tb_mem_interconnect.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared bus widths and FSM state encoding for mem_interconnect
package mem_bus_pkg;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_MASK_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_decoder.sv
// rtl/mem_decoder.sv - combinational address decoder, lowest matching slave index wins
module mem_decoder
   import mem_bus_pkg::*;
#(
   parameter int                               NUM_SLAVES = 5,
   parameter logic [NUM_SLAVES*MEM_ADDR_W-1:0] SLAVE_BASE = '0,
   parameter logic [NUM_SLAVES*MEM_ADDR_W-1:0] SLAVE_MASK = '0,
   parameter int                               IDX_W      = 3
) (
   input  logic [MEM_ADDR_W-1:0] addr_i,
   output logic                  hit_o,
   output logic [IDX_W-1:0]      idx_o
);

   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      // Scan downward so the lowest matching index is the one left standing.
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((addr_i & SLAVE_MASK[i*MEM_ADDR_W +: MEM_ADDR_W]) ==
             SLAVE_BASE[i*MEM_ADDR_W +: MEM_ADDR_W]) begin
            hit_o = 1'b1;
            idx_o = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/mem_interconnect.sv
// rtl/mem_interconnect.sv - single-master to N-slave memory interconnect with address decode
// Define BUS_TIMEOUT_EN to fault an ACCESS that waits TIMEOUT_CYCLES without slave ready.
module mem_interconnect
   import mem_bus_pkg::*;
#(
   parameter int                               NUM_SLAVES     = 5,
   parameter logic [NUM_SLAVES*MEM_ADDR_W-1:0] SLAVE_BASE     = {32'h01000000, 32'h00030000,
                                                                 32'h00020000, 32'h00010000,
                                                                 32'h00000000},
   parameter logic [NUM_SLAVES*MEM_ADDR_W-1:0] SLAVE_MASK     = {32'hFF000000, 32'hFFFFFFF0,
                                                                 32'hFFFFFFF0, 32'hFFFFFFFC,
                                                                 32'hFFFF0000},
   parameter int                               TIMEOUT_CYCLES = 255
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [MEM_ADDR_W-1:0]            address_in,
   input  logic                             read_in,
   input  logic                             write_in,
   input  logic [MEM_MASK_W-1:0]            write_mask_in,
   input  logic [MEM_DATA_W-1:0]            write_value_in,
   output logic [MEM_DATA_W-1:0]            read_value_out,
   output logic                             ready_out,
   output logic                             fault_out,
   output logic [MEM_ADDR_W-1:0]            address_out,
   output logic [MEM_DATA_W-1:0]            write_value_out,
   output logic [MEM_MASK_W-1:0]            write_mask_out,
   output logic                             read_out,
   output logic [NUM_SLAVES-1:0]            sel_out,
   input  logic [NUM_SLAVES*MEM_DATA_W-1:0] slave_read_value_in,
   input  logic [NUM_SLAVES-1:0]            slave_ready_in
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   mem_state_e            state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [MEM_DATA_W-1:0] rdata_q, rdata_d;
   logic                  fault_q, fault_d;

   logic                  req;
   logic                  in_access;
   logic                  dec_hit;
   logic [IDX_W-1:0]      dec_idx;
   logic                  slv_ready;
   logic [MEM_DATA_W-1:0] slv_rdata;
   logic                  timeout;

   mem_decoder #(
      .NUM_SLAVES (NUM_SLAVES),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_MASK (SLAVE_MASK),
      .IDX_W      (IDX_W)
   ) u_decoder (
      .addr_i (address_in),
      .hit_o  (dec_hit),
      .idx_o  (dec_idx)
   );

   assign req             = read_in | write_in;
   assign in_access       = (state_q == ST_ACCESS);
   assign address_out     = address_in;
   assign write_value_out = write_value_in;

   // Only the latched slave is visible; other slaves' ready and data are ignored.
   always_comb begin
      sel_out   = '0;
      slv_ready = 1'b0;
      slv_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_out[i] = in_access;
            slv_ready  = slave_ready_in[i];
            slv_rdata  = slave_read_value_in[i*MEM_DATA_W +: MEM_DATA_W];
         end
      end
   end

   assign read_out       = in_access & read_in;
   assign write_mask_out = (in_access && write_in) ? write_mask_in : '0;
   assign ready_out      = (state_q == ST_DONE);
   assign fault_out      = ready_out & fault_q;
   assign read_value_out = ready_out ? rdata_q : '0;

`ifdef BUS_TIMEOUT_EN
   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign timeout = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_IDLE && req && dec_hit) begin
         cnt_d = '0;
      end else if (in_access && !slv_ready) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (dec_hit) begin
                  idx_d   = dec_idx;
                  state_d = ST_ACCESS;
               end else begin
                  rdata_d = '0;
                  fault_d = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_ACCESS: begin
            // Slave ready takes priority over a timeout expiring in the same cycle.
            if (slv_ready) begin
               rdata_d = slv_rdata;
               fault_d = 1'b0;
               state_d = ST_DONE;
            end else if (timeout) begin
               rdata_d = '0;
               fault_d = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
      end
   end

endmodule

// File: tb/tb_mem_interconnect.sv
// tb/tb_mem_interconnect.sv - directed self-checking bench for mem_interconnect
// Slave 3 is remapped to overlap slave 1 so the lowest-index priority can be observed.
module tb_mem_interconnect;

`ifdef BUS_TIMEOUT_EN
   localparam int TB_TIMEOUT = 4;
`else
   localparam int TB_TIMEOUT = 255;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  address_in;
   logic         read_in;
   logic         write_in;
   logic [3:0]   write_mask_in;
   logic [31:0]  write_value_in;
   logic [31:0]  read_value_out;
   logic         ready_out;
   logic         fault_out;
   logic [31:0]  address_out;
   logic [31:0]  write_value_out;
   logic [3:0]   write_mask_out;
   logic         read_out;
   logic [4:0]   sel_out;
   logic [159:0] slave_read_value_in;
   logic [4:0]   slave_ready_in;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   mem_interconnect #(
      .NUM_SLAVES     (5),
      .SLAVE_BASE     ({32'h01000000, 32'h00010000, 32'h00020000, 32'h00010000, 32'h00000000}),
      .SLAVE_MASK     ({32'hFF000000, 32'hFFFF0000, 32'hFFFFFFF0, 32'hFFFFFFFC, 32'hFFFF0000}),
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .address_in          (address_in),
      .read_in             (read_in),
      .write_in            (write_in),
      .write_mask_in       (write_mask_in),
      .write_value_in      (write_value_in),
      .read_value_out      (read_value_out),
      .ready_out           (ready_out),
      .fault_out           (fault_out),
      .address_out         (address_out),
      .write_value_out     (write_value_out),
      .write_mask_out      (write_mask_out),
      .read_out            (read_out),
      .sel_out             (sel_out),
      .slave_read_value_in (slave_read_value_in),
      .slave_ready_in      (slave_ready_in)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      address_in     = 32'h0;
      read_in        = 1'b0;
      write_in       = 1'b0;
      write_mask_in  = 4'h0;
      write_value_in = 32'h0;
   endtask

   task automatic request(input logic [31:0] a, input logic rd, input logic wr,
                          input logic [3:0] m, input logic [31:0] v);
      address_in     = a;
      read_in        = rd;
      write_in       = wr;
      write_mask_in  = m;
      write_value_in = v;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic stuck;
      idle_bus();
      slave_ready_in      = 5'b00000;
      slave_read_value_in = {32'h44444444, 32'h33333333, 32'h22222222,
                             32'h11111111, 32'hDEADBEEF};
      reset = 1'b1;
      #2;
      check("rst_sel",   32'(sel_out),        32'h0);
      check("rst_ready", 32'(ready_out),      32'h0);
      check("rst_fault", 32'(fault_out),      32'h0);
      check("rst_rdata", read_value_out,      32'h0);
      check("rst_rdstb", 32'(read_out),       32'h0);
      check("rst_wmask", 32'(write_mask_out), 32'h0);
      step();
      step();
      reset = 1'b0;

      // read slave 0, ready at once
      request(32'h00000010, 1'b1, 1'b0, 4'h0, 32'h0);
      slave_ready_in = 5'b00001;
      check("rd0_idle_sel", 32'(sel_out), 32'h0);
      step();
      check("rd0_acc_sel",   32'(sel_out),   32'h01);
      check("rd0_acc_rdstb", 32'(read_out),  32'h1);
      check("rd0_acc_ready", 32'(ready_out), 32'h0);
      step();
      check("rd0_ready", 32'(ready_out), 32'h1);
      check("rd0_data",  read_value_out, 32'hDEADBEEF);
      check("rd0_fault", 32'(fault_out), 32'h0);
      check("rd0_sel",   32'(sel_out),   32'h0);
      idle_bus();
      step();
      check("rd0_after_ready", 32'(ready_out), 32'h0);
      check("rd0_after_data",  read_value_out, 32'h0);

      // unmapped read
      request(32'h00040000, 1'b1, 1'b0, 4'h0, 32'h0);
      slave_ready_in = 5'b11111;
      check("miss_idle_sel", 32'(sel_out), 32'h0);
      step();
      check("miss_ready", 32'(ready_out), 32'h1);
      check("miss_fault", 32'(fault_out), 32'h1);
      check("miss_data",  read_value_out, 32'h0);
      check("miss_sel",   32'(sel_out),   32'h0);
      idle_bus();
      step();
      check("miss_after_fault", 32'(fault_out), 32'h0);
      check("miss_after_ready", 32'(ready_out), 32'h0);

      // write slave 1 (overlaps slave 3, lower index wins)
      request(32'h00010000, 1'b0, 1'b1, 4'b0001, 32'h0000005A);
      slave_ready_in = 5'b00010;
      check("wr_addr_pass",  address_out,          32'h00010000);
      check("wr_data_pass",  write_value_out,      32'h0000005A);
      check("wr_idle_wmask", 32'(write_mask_out),  32'h0);
      step();
      check("wr_acc_sel",   32'(sel_out),        32'h02);
      check("wr_acc_wmask", 32'(write_mask_out), 32'h1);
      check("wr_acc_rdstb", 32'(read_out),       32'h0);
      step();
      check("wr_ready", 32'(ready_out), 32'h1);
      check("wr_fault", 32'(fault_out), 32'h0);
      idle_bus();
      step();

      // address only slave 3 decodes
      request(32'h00010004, 1'b1, 1'b0, 4'h0, 32'h0);
      slave_ready_in = 5'b01000;
      step();
      check("s3_sel", 32'(sel_out), 32'h08);
      step();
      check("s3_data", read_value_out, 32'h33333333);
      idle_bus();
      step();

      // unselected readies ignored, request withdrawn mid-ACCESS, back-to-back
      request(32'h00020000, 1'b1, 1'b0, 4'h0, 32'h0);
      slave_ready_in = 5'b11011;
      step();
      check("s2_sel", 32'(sel_out), 32'h04);
      step();
      check("s2_ignore_ready", 32'(ready_out), 32'h0);
      idle_bus();
      step();
      check("wd_sel",   32'(sel_out),   32'h04);
      check("wd_rdstb", 32'(read_out),  32'h0);
      check("wd_ready", 32'(ready_out), 32'h0);
      slave_ready_in = 5'b00100;
      step();
      check("wd_done_ready", 32'(ready_out), 32'h1);
      check("wd_done_data",  read_value_out, 32'h22222222);
      check("wd_done_fault", 32'(fault_out), 32'h0);
      request(32'h00040000, 1'b1, 1'b0, 4'h0, 32'h0);
      slave_ready_in = 5'b00000;
      step();
      check("b2b_idle_ready", 32'(ready_out), 32'h0);
      step();
      check("b2b_ready", 32'(ready_out), 32'h1);
      check("b2b_fault", 32'(fault_out), 32'h1);
      idle_bus();
      step();

      // reset during the second ACCESS cycle
      request(32'h00020000, 1'b1, 1'b0, 4'h0, 32'h0);
      slave_ready_in = 5'b00000;
      step();
      step();
      check("rsta_sel_before", 32'(sel_out), 32'h04);
      #2;
      reset = 1'b1;
      #1;
      check("rsta_sel",   32'(sel_out),   32'h0);
      check("rsta_rdstb", 32'(read_out),  32'h0);
      check("rsta_ready", 32'(ready_out), 32'h0);
      check("rsta_fault", 32'(fault_out), 32'h0);
      check("rsta_data",  read_value_out, 32'h0);
      idle_bus();
      #1;
      reset = 1'b0;
      request(32'h00000010, 1'b1, 1'b0, 4'h0, 32'h0);
      slave_ready_in = 5'b00001;
      step();
      check("post_rst_sel", 32'(sel_out), 32'h01);
      step();
      check("post_rst_ready", 32'(ready_out), 32'h1);
      check("post_rst_data",  read_value_out, 32'hDEADBEEF);
      idle_bus();
      step();

`ifdef BUS_TIMEOUT_EN
      // slave 2 never ready: fault after 4 ACCESS cycles
      request(32'h00020000, 1'b1, 1'b0, 4'h0, 32'h0);
      slave_ready_in = 5'b00000;
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("to_wait%0d", k), 32'(ready_out), 32'h0);
      end
      step();
      check("to_ready", 32'(ready_out), 32'h1);
      check("to_fault", 32'(fault_out), 32'h1);
      check("to_data",  read_value_out, 32'h0);
      idle_bus();
      step();

      // ready on the expiring cycle beats the timeout
      request(32'h00020000, 1'b1, 1'b0, 4'h0, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         step();
      end
      slave_ready_in = 5'b00100;
      step();
      check("to_win_ready", 32'(ready_out), 32'h1);
      check("to_win_fault", 32'(fault_out), 32'h0);
      check("to_win_data",  read_value_out, 32'h22222222);
      idle_bus();
      step();
`else
      // without the timeout, ACCESS waits past any counter limit
      request(32'h00020000, 1'b1, 1'b0, 4'h0, 32'h0);
      slave_ready_in = 5'b00000;
      stuck = 1'b0;
      for (int k = 0; k < 300; k++) begin
         step();
         if (ready_out) stuck = 1'b1;
      end
      check("no_to_wait", 32'(stuck), 32'h0);
      slave_ready_in = 5'b00100;
      step();
      check("no_to_ready", 32'(ready_out), 32'h1);
      check("no_to_fault", 32'(fault_out), 32'h0);
      idle_bus();
      step();
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
